// File: rtl/fa4_pkg.sv
// Shared width constant and operand type for the 4-bit ripple-carry adder.
package fa4_pkg;

  localparam int FA4_W = 4;

  typedef logic [FA4_W-1:0] fa4_t;

endpackage

// File: rtl/fa1_bit.sv
// One-bit full adder: the ripple stage used by fa4_inst.
module fa1_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/fa4_inst.sv
// Registered 4-bit ripple-carry adder with carry-out and signed overflow.
// Define FA4_INST_INREG_EN to add an input register stage (latency 2 instead of 1).
module fa4_inst
  import fa4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [FA4_W-1:0] a,
  input  logic [FA4_W-1:0] b,
  input  logic             ci,
  output logic [FA4_W-1:0] s,
  output logic             co,
  output logic             ovf
);

  fa4_t             a_op;
  fa4_t             b_op;
  logic             ci_op;
  fa4_t             sum_next;
  logic [FA4_W:0]   carry;
  fa4_t             s_reg;
  logic             co_reg;
  logic             ovf_reg;

`ifdef FA4_INST_INREG_EN
  fa4_t a_reg;
  fa4_t b_reg;
  logic ci_reg;

  // Clearing the input stage on reset keeps stale operands out of the output after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      ci_reg <= 1'b0;
    end else begin
      a_reg  <= a;
      b_reg  <= b;
      ci_reg <= ci;
    end
  end

  assign a_op  = a_reg;
  assign b_op  = b_reg;
  assign ci_op = ci_reg;
`else
  assign a_op  = a;
  assign b_op  = b;
  assign ci_op = ci;
`endif

  assign carry[0] = ci_op;

  generate
    for (genvar gi = 0; gi < FA4_W; gi++) begin : g_stage
      fa1_bit u_fa (
        .x    (a_op[gi]),
        .y    (b_op[gi]),
        .cin  (carry[gi]),
        .sum  (sum_next[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg   <= '0;
      co_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      s_reg   <= sum_next;
      co_reg  <= carry[FA4_W];
      // Signed overflow: carry into the sign bit disagrees with carry out of it.
      ovf_reg <= carry[FA4_W-1] ^ carry[FA4_W];
    end
  end

  assign s   = s_reg;
  assign co  = co_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_fa4_inst.sv
// Bench for fa4_inst: arithmetic reference model checked every cycle plus directed literal vectors.
module tb_fa4_inst;
  import fa4_pkg::*;

`ifdef FA4_INST_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int HMAX = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a   = 4'd0;
  logic [3:0] b   = 4'd0;
  logic       ci  = 1'b0;
  logic [3:0] s;
  logic       co;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit running = 1'b1;

  logic       h_rst [0:HMAX-1];
  logic [3:0] h_a   [0:HMAX-1];
  logic [3:0] h_b   [0:HMAX-1];
  logic       h_ci  [0:HMAX-1];

  always #5 clk = ~clk;

  fa4_inst dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .ci  (ci),
    .s   (s),
    .co  (co),
    .ovf (ovf)
  );

  // Reference: plain unsigned and signed integer arithmetic, returns {ovf, co, s}.
  function automatic logic [5:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mci);
    int total;
    int sa;
    int sb;
    int ssum;
    logic [5:0] r;
    total = int'(ma) + int'(mb) + int'(mci);
    sa    = (ma >= 4'd8) ? int'(ma) - 16 : int'(ma);
    sb    = (mb >= 4'd8) ? int'(mb) - 16 : int'(mb);
    ssum  = sa + sb + int'(mci);
    r[3:0] = 4'(total % 16);
    r[4]   = (total >= 16);
    r[5]   = (ssum > 7) || (ssum < -8);
    return r;
  endfunction

  always @(posedge clk) begin
    if (cyc < HMAX) begin
      h_rst[cyc] <= rst;
      h_a[cyc]   <= a;
      h_b[cyc]   <= b;
      h_ci[cyc]  <= ci;
    end
    cyc <= cyc + 1;
  end

  // Every cycle: output after edge k reflects inputs of edge k-LAT+1 unless reset hit the window.
  always @(negedge clk) begin
    if (running && cyc >= LAT && cyc <= HMAX) begin
      int k;
      logic any_rst;
      logic [5:0] exp_v;
      k = cyc - 1;
      any_rst = 1'b0;
      for (int j = k - LAT + 1; j <= k; j++) any_rst |= h_rst[j];
      exp_v = any_rst ? 6'd0 : model(h_a[k-LAT+1], h_b[k-LAT+1], h_ci[k-LAT+1]);
      checks++;
      if ({ovf, co, s} !== exp_v) begin
        errors++;
        $display("FAIL model cyc=%0d got ovf=%b co=%b s=%0d want ovf=%b co=%b s=%0d",
                 k, ovf, co, s, exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] es, input logic eco, input logic eovf);
    checks++;
    if (s !== es || co !== eco || ovf !== eovf) begin
      errors++;
      $display("FAIL %s got s=%0d co=%b ovf=%b want s=%0d co=%b ovf=%b",
               name, s, co, ovf, es, eco, eovf);
    end else begin
      $display("ok   %s a=%0d b=%0d ci=%b -> s=%0d co=%b ovf=%b", name, a, b, ci, s, co, ovf);
    end
  endtask

  task automatic apply(input string name, input logic [3:0] va, input logic [3:0] vb, input logic vci,
                       input logic [3:0] es, input logic eco, input logic eovf);
    a = va; b = vb; ci = vci;
    repeat (LAT) @(negedge clk);
    chk(name, es, eco, eovf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; a = 4'd9; b = 4'd8; ci = 1'b1;
    @(negedge clk); chk("reset_1", 4'd0, 1'b0, 1'b0);
    @(negedge clk); chk("reset_2", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("first_after_rst", 4'd2, 1'b1, 1'b1);

    apply("15+0+1",  4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0);
    apply("0+0+0",   4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0);
    apply("7+1+0",   4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1);
    apply("15+15+1", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);
    apply("8+8+0",   4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1);
    apply("5+6+1",   4'd5,  4'd6,  1'b1, 4'd12, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold", 4'd12, 1'b0, 1'b1);

    // Back-to-back stream; per-cycle model covers each result's timing.
    for (int i = 0; i < 16; i++) begin
      a = 4'(i); b = 4'(15 - i); ci = i[0];
      @(negedge clk);
    end

    // Reset pulse mid-stream, then new operands with no stale result.
    a = 4'd3; b = 4'd4; ci = 1'b0;
    @(negedge clk);
    a = 4'd9; b = 4'd9; ci = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", 4'd0, 1'b0, 1'b0);
    rst = 1'b0; a = 4'd1; b = 4'd2; ci = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("after_mid_rst", 4'd4, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      a  = 4'($urandom_range(15));
      b  = 4'($urandom_range(15));
      ci = 1'($urandom_range(1));
      @(negedge clk);
    end
    repeat (LAT + 1) @(negedge clk);
    running = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fa4_inst.md
FA4_INST -- requirements
Module: fa4_inst

Interface
- REQ-001: The block SHALL have no parameters; operand width is fixed at 4 by the package constant FA4_W = 4.
- REQ-002: Port clk, input, 1, single rising-edge clock for all state.
- REQ-003: Port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
- REQ-004: Port a, input, 4, unsigned operand A.
- REQ-005: Port b, input, 4, unsigned operand B.
- REQ-006: Port ci, input, 1, carry-in.
- REQ-007: Port s, output, 4, registered sum bits [3:0].
- REQ-008: Port co, output, 1, registered carry-out (sum bit 4).
- REQ-009: Port ovf, output, 1, registered two's-complement overflow flag.

Function
- REQ-010: {co, s} SHALL equal a + b + ci as a 5-bit unsigned result, with no truncation and no saturation.
- REQ-011: ovf SHALL equal the carry into bit 3 XOR the carry out of bit 3 (signed overflow when a and b are read as 4-bit two's complement).
- REQ-012: The sum SHALL be formed as a 4-stage ripple-carry chain of 1-bit full-adder instances, with stage 0 carry-in = ci and stage 3 carry-out = co.
- REQ-013: Each stage SHALL compute sum = x ^ y ^ cin and cout = (x & y) | (cin & (x ^ y)).
- REQ-014: Without FA4_INST_INREG_EN, s, co and ovf SHALL update on the rising clk edge after the inputs are sampled, giving 1-cycle latency.
- REQ-015: A new operand set SHALL be accepted every cycle; there is no handshake and no stall.
- REQ-016: Outputs SHALL hold their last value while the inputs are unchanged.
- REQ-017: Wrap-around: a=15, b=15, ci=1 SHALL produce s=15, co=1, with ovf per REQ-011 (0).

Reset
- REQ-018: While rst=1 at a rising clk edge, s SHALL become 0, co SHALL become 0 and ovf SHALL become 0; any input pipeline register SHALL also become 0.
- REQ-019: Reset SHALL take priority over a simultaneous operand capture.
- REQ-020: The first valid result after rst deasserts SHALL appear after the normal latency, counted from the first edge with rst=0.
- REQ-021: Reset asserted mid-operation SHALL discard any in-flight result.

Configuration
- REQ-022: With macro FA4_INST_INREG_EN defined, a, b and ci SHALL first be captured in an input register stage, giving a total latency of 2 cycles.
- REQ-023: Without FA4_INST_INREG_EN, no input register SHALL exist and latency SHALL be 1 cycle.
- REQ-024: The function SHALL be identical in both builds apart from the latency.

Structure
- REQ-025: Package fa4_pkg SHALL hold FA4_W and a typedef for the 4-bit operand type.
- REQ-026: One sub-module, fa1_bit (ports x, y, cin, sum, cout, purely combinational), SHALL be instantiated 4 times.

Verification
- REQ-027: rst=1 for 2 cycles with a=9, b=8, ci=1 -> s=0, co=0, ovf=0 throughout reset.
- REQ-028: a=9, b=8, ci=1 -> after latency s=2, co=1, ovf=1.
- REQ-029: a=15, b=0, ci=1 -> s=0, co=1, ovf=0; a=0, b=0, ci=0 -> s=0, co=0, ovf=0.
- REQ-030: a=7, b=1, ci=0 -> s=8, co=0, ovf=1.
- REQ-031: Back-to-back operands on consecutive cycles -> each result appears exactly latency cycles later; rst pulsed mid-stream -> outputs 0, and no stale result appears after release.
- REQ-032: 1000 random {ci, a, b} vectors -> {co, s} matches a + b + ci and ovf matches a reference model, in both macro builds.
